// File: rtl/hdmi_i2c_master.sv
// Purpose: open-loop I2C master for HDMI transmitter setup: 1-2 byte writes or a one-byte read.
// Latency: END drops on the launch edge and rises (3 + 36*bytes + 3) SCL quarters later.
// Backpressure: none; START edges are ignored while END=0, and clock stretching is not honoured.
module hdmi_i2c_master #(
    parameter int CLK_Freq = 50_000_000,
    parameter int I2C_Freq = 20_000
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       START,
    input  logic       READ,
    input  logic [6:0] I2C_ADDR,
    input  logic       I2C_WLEN,
    input  logic [7:0] I2C_WDATA1,
    input  logic [7:0] I2C_WDATA2,
    output logic [7:0] I2C_RDATA,
    output logic       END,
    output logic       ACK,
    output wire        I2C_SCL,
    inout  wire        I2C_SDA
);

    // iCLK cycles per SCL quarter period; must be at least 2.
    localparam int QTR = CLK_Freq / (4 * I2C_Freq);
    localparam int QW  = (QTR > 2) ? $clog2(QTR) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STA,
        S_BYTE,
        S_ACK,
        S_STO
    } state_t;

    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    qph_q, qph_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic          rd_q, rd_d;
    logic          wlen_q, wlen_d;
    logic [7:0]    wd1_q, wd1_d;
    logic [7:0]    wd2_q, wd2_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          end_q, end_d;
    logic          ack_q, ack_d;
    logic          start_q, start_d;
    logic          smp_q, smp_d;

    logic          tick;
    logic          rx_mode;
    logic          sda_in;
    logic          scl_low;
    logic          sda_low;

    assign sda_in  = I2C_SDA;
    assign tick    = (qcnt_q == QW'(QTR - 1));
    // Byte 1 of a read transfer is shifted in from the slave instead of driven.
    assign rx_mode = rd_q && (byte_q == 2'd1);

    // State register; reset releases the bus immediately through the output decode.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_IDLE;
            qcnt_q  <= '0;
            qph_q   <= 2'd0;
            bit_q   <= 3'd7;
            byte_q  <= 2'd0;
            tx_q    <= 8'h00;
            rx_q    <= 8'h00;
            rd_q    <= 1'b0;
            wlen_q  <= 1'b0;
            wd1_q   <= 8'h00;
            wd2_q   <= 8'h00;
            rdata_q <= 8'h00;
            end_q   <= 1'b1;
            ack_q   <= 1'b0;
            start_q <= 1'b0;
            smp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            qph_q   <= qph_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rd_q    <= rd_d;
            wlen_q  <= wlen_d;
            wd1_q   <= wd1_d;
            wd2_q   <= wd2_d;
            rdata_q <= rdata_d;
            end_q   <= end_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            smp_q   <= smp_d;
        end
    end

    // Next-state logic: quarter timing, bit/byte sequencing, launch and completion.
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        qph_d   = qph_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rd_d    = rd_q;
        wlen_d  = wlen_q;
        wd1_d   = wd1_q;
        wd2_d   = wd2_q;
        rdata_d = rdata_q;
        end_d   = end_q;
        ack_d   = ack_q;
        start_d = START;
        smp_d   = smp_q;

        // Quarter counter free-runs while busy; each wrap steps the quarter phase.
        if (state_q != S_IDLE) begin
            qcnt_d = tick ? '0 : qcnt_q + QW'(1);
            if (tick) begin
                qph_d = qph_q + 2'd1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                qcnt_d = '0;
                qph_d  = 2'd0;
                if (START && !start_q && end_q) begin
                    state_d = S_STA;
                    end_d   = 1'b0;
                    ack_d   = 1'b0;
                    rd_d    = READ;
                    wlen_d  = I2C_WLEN;
                    wd1_d   = I2C_WDATA1;
                    wd2_d   = I2C_WDATA2;
                    tx_d    = {I2C_ADDR, READ};
                    byte_d  = 2'd0;
                    bit_d   = 3'd7;
                end
            end
            S_STA: begin
                if (tick && qph_q == 2'd2) begin
                    state_d = S_BYTE;
                    qph_d   = 2'd0;
                    bit_d   = 3'd7;
                end
            end
            S_BYTE: begin
                // Slave data is taken on the edge that opens q2 (SCL about to rise).
                if (tick && qph_q == 2'd1 && rx_mode) begin
                    rx_d = {rx_q[6:0], sda_in};
                end
                if (tick && qph_q == 2'd3) begin
                    if (bit_q == 3'd0) begin
                        state_d = S_ACK;
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            S_ACK: begin
                if (tick && qph_q == 2'd1) begin
                    smp_d = sda_in;
                end
                if (tick && qph_q == 2'd3) begin
                    bit_d = 3'd7;
                    if (rx_mode) begin
                        // Master NACK slot done: publish the received byte and stop.
                        rdata_d = rx_q;
                        state_d = S_STO;
                    end else if (smp_q) begin
                        ack_d   = 1'b1;
                        state_d = S_STO;
                    end else if (byte_q == 2'd0) begin
                        byte_d  = 2'd1;
                        tx_d    = wd1_q;
                        state_d = S_BYTE;
                    end else if (byte_q == 2'd1 && wlen_q) begin
                        byte_d  = 2'd2;
                        tx_d    = wd2_q;
                        state_d = S_BYTE;
                    end else begin
                        state_d = S_STO;
                    end
                end
            end
            S_STO: begin
                if (tick && qph_q == 2'd2) begin
                    state_d = S_IDLE;
                    end_d   = 1'b1;
                    qph_d   = 2'd0;
                    qcnt_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus drive decode: SCL low in q0/q1 of every bit, START/STOP shapes in STA/STO.
    always_comb begin
        scl_low = 1'b0;
        sda_low = 1'b0;
        unique case (state_q)
            S_STA: begin
                scl_low = (qph_q == 2'd2);
                sda_low = (qph_q != 2'd0);
            end
            S_BYTE: begin
                scl_low = !qph_q[1];
                sda_low = !rx_mode && !tx_q[bit_q];
            end
            S_ACK: begin
                scl_low = !qph_q[1];
            end
            S_STO: begin
                scl_low = (qph_q == 2'd0);
                sda_low = !qph_q[1];
            end
            default: begin
                scl_low = 1'b0;
                sda_low = 1'b0;
            end
        endcase
    end

    // Open-drain outputs: only ever pull low or release.
    assign I2C_SCL = scl_low ? 1'b0 : 1'bz;
    assign I2C_SDA = sda_low ? 1'b0 : 1'bz;

    assign END       = end_q;
    assign ACK       = ack_q;
    assign I2C_RDATA = rdata_q;

endmodule

// File: tb/tb_hdmi_i2c_master.sv
// Purpose: directed bench for hdmi_i2c_master with a quarter-level bus model and scripted slave.
// Latency: expected bus waveform is checked every iCLK cycle from the launch edge to END=1.
// Backpressure: not applicable; the slave only answers ACK slots and read data bits.
module tb_hdmi_i2c_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       rd;
    logic [6:0] addr;
    logic       wlen;
    logic [7:0] wd1;
    logic [7:0] wd2;
    logic       slv_low;
    wire  [7:0] rdata;
    wire        end_o;
    wire        ack_o;
    wire        scl_w;
    wire        sda_w;

    pullup (scl_w);
    pullup (sda_w);
    assign sda_w = slv_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    hdmi_i2c_master #(
        .CLK_Freq(400),
        .I2C_Freq(20)
    ) dut (
        .iCLK      (clk),
        .iRST_N    (rst_n),
        .START     (start),
        .READ      (rd),
        .I2C_ADDR  (addr),
        .I2C_WLEN  (wlen),
        .I2C_WDATA1(wd1),
        .I2C_WDATA2(wd2),
        .I2C_RDATA (rdata),
        .END       (end_o),
        .ACK       (ack_o),
        .I2C_SCL   (scl_w),
        .I2C_SDA   (sda_w)
    );

    int passed = 0;
    int total  = 0;

    // Expected bus per SCL quarter: scl level, master SDA release, slave SDA release.
    bit q_scl[$];
    bit q_m[$];
    bit q_s[$];

    // Bus monitor state.
    bit cap[$];
    int hs_cnt;
    int low_cnt;
    bit prev_scl = 1'b1;
    bit prev_sda = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic push_q(input bit c, input bit m, input bit s);
        q_scl.push_back(c);
        q_m.push_back(m);
        q_s.push_back(s);
    endtask

    // One bit slot: SCL low for two quarters, high for two, data constant throughout.
    task automatic push_bit(input bit m, input bit s);
        push_q(1'b0, m, s);
        push_q(1'b0, m, s);
        push_q(1'b1, m, s);
        push_q(1'b1, m, s);
    endtask

    // nack[k]=1 means the slave leaves ACK slot k high.
    task automatic build(input bit r, input logic [6:0] a, input bit wl, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [2:0] nack, input logic [7:0] rb);
        logic [7:0] b;
        q_scl.delete();
        q_m.delete();
        q_s.delete();
        push_q(1'b1, 1'b1, 1'b1);
        push_q(1'b1, 1'b0, 1'b1);
        push_q(1'b0, 1'b0, 1'b1);
        b = {a, r};
        for (int i = 7; i >= 0; i--) push_bit(b[i], 1'b1);
        push_bit(1'b1, nack[0]);
        if (!nack[0]) begin
            if (r) begin
                for (int i = 7; i >= 0; i--) push_bit(1'b1, rb[i]);
                push_bit(1'b1, 1'b1);
            end else begin
                for (int i = 7; i >= 0; i--) push_bit(d1[i], 1'b1);
                push_bit(1'b1, nack[1]);
                if (!nack[1] && wl) begin
                    for (int i = 7; i >= 0; i--) push_bit(d2[i], 1'b1);
                    push_bit(1'b1, nack[2]);
                end
            end
        end
        push_q(1'b0, 1'b0, 1'b1);
        push_q(1'b1, 1'b0, 1'b1);
        push_q(1'b1, 1'b1, 1'b1);
    endtask

    // One iCLK cycle: drive slave after the edge, compare bus and END on the falling edge.
    task automatic cyc(input bit e_scl, input bit e_sda, input bit e_end, input bit s_low,
                       input bit do_rst, input int j);
        bit cs;
        bit cd;
        @(posedge clk);
        #1;
        slv_low = s_low;
        if (do_rst) rst_n = 1'b0;
        @(negedge clk);
        cs = (scl_w !== 1'b0);
        cd = (sda_w !== 1'b0);
        check($sformatf("scl@%0d", j), {31'd0, cs}, {31'd0, e_scl});
        check($sformatf("sda@%0d", j), {31'd0, cd}, {31'd0, e_sda});
        check($sformatf("end@%0d", j), {31'd0, end_o}, {31'd0, e_end});
        if (!prev_scl && cs) cap.push_back(cd);
        if (prev_scl && cs && (prev_sda != cd)) hs_cnt++;
        if (end_o === 1'b0) low_cnt++;
        prev_scl = cs;
        prev_sda = cd;
    endtask

    function automatic int cap_byte(input int k);
        int v = 0;
        if (cap.size() < 9 * k + 9) return -1;
        for (int i = 0; i < 8; i++) v = (v << 1) | int'(cap[9 * k + i]);
        return v;
    endfunction

    task automatic run_xfer(input bit r, input logic [6:0] a, input bit wl, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [2:0] nack, input logic [7:0] rb,
                            input bit from_reset, input bit hold, input int abort_at);
        int nq;
        build(r, a, wl, d1, d2, nack, rb);
        nq      = q_scl.size();
        rd      = r;
        addr    = a;
        wlen    = wl;
        wd1     = d1;
        wd2     = d2;
        cap.delete();
        hs_cnt  = 0;
        low_cnt = 0;
        if (from_reset) begin
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end else begin
            start = 1'b0;
            @(posedge clk);
            #1;
            start = 1'b1;
        end
        for (int j = 0; j <= 5 * nq; j++) begin
            bit es;
            bit ed;
            bit ee;
            bit ss;
            if (j < 5 * nq) begin
                es = q_scl[j / 5];
                ed = q_m[j / 5] & q_s[j / 5];
                ss = q_s[j / 5];
                ee = 1'b0;
            end else begin
                es = 1'b1;
                ed = 1'b1;
                ss = 1'b1;
                ee = 1'b1;
            end
            if (j == abort_at) begin
                cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, j);
                break;
            end
            cyc(es, ed, ee, !ss, 1'b0, j);
            if (j == 20) begin
                rd   = ~r;
                addr = ~a;
                wlen = ~wl;
                wd1  = ~d1;
                wd2  = ~d2;
            end
            if (!hold && j == 50) start = 1'b0;
            if (!hold && j == 60) start = 1'b1;
            if (!hold && j == 70) start = 1'b0;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b1;
        rd      = 1'b0;
        addr    = 7'h39;
        wlen    = 1'b1;
        wd1     = 8'h98;
        wd2     = 8'h03;
        slv_low = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_end", {31'd0, end_o}, 32'd1);
        check("rst_ack", {31'd0, ack_o}, 32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'h00);
        check("rst_scl", {31'd0, scl_w !== 1'b0}, 32'd1);
        check("rst_sda", {31'd0, sda_w !== 1'b0}, 32'd1);

        // START already high when reset releases: one full two-byte write.
        run_xfer(1'b0, 7'h39, 1'b1, 8'h98, 8'h03, 3'b000, 8'h00, 1'b1, 1'b0, -1);
        check("w2_b0", cap_byte(0), 32'h72);
        check("w2_b1", cap_byte(1), 32'h98);
        check("w2_b2", cap_byte(2), 32'h03);
        check("w2_edges", cap.size(), 32'd28);
        check("w2_hs", hs_cnt, 32'd2);
        check("w2_busy", low_cnt, 32'd570);
        check("w2_ack", {31'd0, ack_o}, 32'd0);
        check("w2_rdata", {24'd0, rdata}, 32'h00);

        // Slave NACKs WDATA1: STOP right after that slot, WDATA2 never sent.
        run_xfer(1'b0, 7'h39, 1'b1, 8'h98, 8'h03, 3'b010, 8'h00, 1'b0, 1'b0, -1);
        check("nk_b1", cap_byte(1), 32'h98);
        check("nk_slot", {31'd0, cap[17]}, 32'd1);
        check("nk_edges", cap.size(), 32'd19);
        check("nk_busy", low_cnt, 32'd390);
        check("nk_ack", {31'd0, ack_o}, 32'd1);

        // One-byte read returning 8'hA5, master NACKs it.
        run_xfer(1'b1, 7'h39, 1'b0, 8'h00, 8'h00, 3'b000, 8'hA5, 1'b0, 1'b0, -1);
        check("rd_b0", cap_byte(0), 32'h73);
        check("rd_b1", cap_byte(1), 32'hA5);
        check("rd_mnack", {31'd0, cap[17]}, 32'd1);
        check("rd_rdata", {24'd0, rdata}, 32'hA5);
        check("rd_ack", {31'd0, ack_o}, 32'd0);

        // Single-byte write with START held high afterwards: no retrigger.
        run_xfer(1'b0, 7'h39, 1'b0, 8'h3C, 8'hFF, 3'b000, 8'h00, 1'b0, 1'b1, -1);
        check("w1_b1", cap_byte(1), 32'h3C);
        check("w1_edges", cap.size(), 32'd19);
        for (int i = 0; i < 200; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1000 + i);
        check("w1_busy", low_cnt, 32'd390);
        check("w1_ack", {31'd0, ack_o}, 32'd0);
        check("w1_rdata", {24'd0, rdata}, 32'hA5);
        start = 1'b0;

        // Reset during byte 1: bus released at once, no STOP, outputs back to reset values.
        run_xfer(1'b0, 7'h39, 1'b1, 8'h98, 8'h03, 3'b000, 8'h00, 1'b0, 1'b0, 250);
        check("ab_end", {31'd0, end_o}, 32'd1);
        check("ab_ack", {31'd0, ack_o}, 32'd0);
        check("ab_rdata", {24'd0, rdata}, 32'h00);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2000 + i);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3000 + i);

        // Full transfer after reset: address NACK ends it after the first slot.
        run_xfer(1'b0, 7'h50, 1'b1, 8'h11, 8'h22, 3'b001, 8'h00, 1'b0, 1'b0, -1);
        check("an_b0", cap_byte(0), 32'hA0);
        check("an_edges", cap.size(), 32'd10);
        check("an_busy", low_cnt, 32'd210);
        check("an_hs", hs_cnt, 32'd2);
        check("an_ack", {31'd0, ack_o}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hdmi_i2c_master.md
HDMI_I2C_MASTER -- requirements
Module: hdmi_i2c_master

Interface
REQ-001 SHALL have parameter CLK_Freq, default 50_000_000, meaning the iCLK frequency in Hz.
REQ-002 SHALL have parameter I2C_Freq, default 20_000, meaning the SCL bit rate in Hz.
REQ-003 SHALL derive localparam QTR = CLK_Freq/(4*I2C_Freq), meaning iCLK cycles per SCL quarter-period; QTR SHALL be at least 2.
REQ-004 Clock and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-005 iCLK  input  1  system clock; all logic rises on iCLK.
REQ-006 iRST_N  input  1  asynchronous active-low reset.
REQ-007 START  input  1  transfer request; rising edge while idle launches a transfer.
REQ-008 READ  input  1  0 = write transfer, 1 = one-byte read; sampled at launch.
REQ-009 I2C_ADDR  input  7  slave address; sampled at launch.
REQ-010 I2C_WLEN  input  1  0 = send WDATA1 only, 1 = send WDATA1 then WDATA2; sampled at launch.
REQ-011 I2C_WDATA1 / I2C_WDATA2  input  8 each  write payload bytes, MSB first; sampled at launch.
REQ-012 I2C_RDATA  output  8  byte received by the last read transfer.
REQ-013 END  output  1  1 = idle/complete, 0 = transfer in progress.
REQ-014 ACK  output  1  0 = every slave ACK slot was low, 1 = a NACK was seen in the last transfer.
REQ-015 I2C_SCL  output  1  bus clock; driven 0 or released (1'bz).
REQ-016 I2C_SDA  inout  1  bus data; driven 0 or released (1'bz); never driven 1.

Function
REQ-017 SHALL run a quarter-tick counter 0..QTR-1 while busy; each wrap advances one quarter phase q0..q3.
REQ-018 Data bit: q0/q1 SCL low, SDA set at q0 start; q2/q3 SCL released; SDA sampled at start of q2; SDA SHALL change only while SCL is low.
REQ-019 States: IDLE, STA, BYTE (8 data bits), ACKBIT, STO, with byte index 0..2.
REQ-020 IDLE -> STA when a START rising edge is seen (START=1, previous START=0) and END=1; END SHALL go 0 on the next iCLK edge; ACK SHALL clear to 0 at launch.
REQ-021 STA: SDA and SCL released for one quarter, SDA low for one quarter with SCL released, then SCL low for one quarter -> BYTE.
REQ-022 Byte 0 SHALL be {I2C_ADDR, READ}; write: byte 1 = WDATA1, byte 2 = WDATA2 only if WLEN=1; read: byte 1 is received.
REQ-023 ACKBIT after a transmitted byte: SDA released; sampled 1 sets ACK=1 and jumps to STO, skipping remaining bytes.
REQ-024 ACKBIT after the received read byte: master SHALL release SDA (NACK); I2C_RDATA SHALL update at the end of that ACKBIT.
REQ-025 STO: SDA low with SCL low one quarter, SCL released one quarter, SDA released one quarter, then END=1 and return to IDLE.
REQ-026 START held high after completion SHALL NOT retrigger; START must return to 0 first.
REQ-027 START edges while END=0 SHALL be ignored; latched inputs SHALL not change mid-transfer.
REQ-028 Clock stretching is not supported; SCL timing is open-loop.

Reset
REQ-029 While iRST_N=0: END=1, ACK=0, I2C_RDATA=8'h00, SCL and SDA released, state IDLE, counters 0, START history 0.
REQ-030 Reset asserted mid-transfer SHALL release the bus on the asserting edge without issuing a STOP.
REQ-031 After reset release, a START already high SHALL launch one transfer (history is 0).

Verification (CLK_Freq=400, I2C_Freq=20, QTR=5)
REQ-032 Write ADDR=7'h39, WLEN=1, WDATA 8'h98/8'h03, slave ACKs all -> bus bytes 8'h72, 8'h98, 8'h03, STOP, END 0->1, ACK=0.
REQ-033 Same write, slave NACKs byte 1 (8'h98) -> STOP directly after that ACK slot, 8'h03 never sent, ACK=1, END=1.
REQ-034 READ=1, ADDR=7'h39, slave returns 8'hA5 -> bus byte 8'h73, master NACK, STOP, I2C_RDATA=8'hA5, ACK=0.
REQ-035 WLEN=0 write -> exactly two bytes on bus; START held high 200 cycles after END=1 -> no second transfer.
REQ-036 iRST_N low during byte 1 -> SCL/SDA released same edge, END=1, ACK=0; next START edge performs a complete transfer.
REQ-037 Checker on all runs: SDA never changes while SCL is high except in STA/STO; SCL high and low quarters each last exactly 5 cycles.
